// File: rtl/reg_fifo_if.sv
// rtl/reg_fifo_if.sv - reg_fifo request/status bundle; REG_FIFO_NOUT_EN adds dout_n
interface reg_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             udf;
`ifdef REG_FIFO_NOUT_EN
    logic [WIDTH-1:0] dout_n;

    modport master (output wr_en, din, rd_en,
                    input  dout, dout_n, full, empty, count, ovf, udf);
    modport slave  (input  wr_en, din, rd_en,
                    output dout, dout_n, full, empty, count, ovf, udf);
`else
    modport master (output wr_en, din, rd_en,
                    input  dout, full, empty, count, ovf, udf);
    modport slave  (input  wr_en, din, rd_en,
                    output dout, full, empty, count, ovf, udf);
`endif
endinterface

// File: rtl/reg_fifo.sv
// rtl/reg_fifo.sv - register FIFO with registered dout and ovf/udf pulses; REG_FIFO_NOUT_EN adds dout_n
module reg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    reg_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dout_q;
    logic             ovf_q;
    logic             udf_q;

    logic full_w;
    logic empty_w;
    logic do_rd;
    logic do_wr;

    assign full_w  = (cnt == CW'(DEPTH));
    assign empty_w = (cnt == '0);
    assign do_rd   = bus.rd_en && !empty_w;
    // A full FIFO still takes a write when the same edge frees a slot; empty never bypasses.
    assign do_wr   = bus.wr_en && (!full_w || do_rd);

    // Storage is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (!reset && do_wr) begin
            mem[wp] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            ovf_q <= bus.wr_en && full_w && !do_rd;
            udf_q <= bus.rd_en && empty_w;
            if (do_wr) begin
                wp <= wp + 1'b1;
            end
            if (do_rd) begin
                rp     <= rp + 1'b1;
                dout_q <= mem[rp];
            end
            if (do_wr && !do_rd) begin
                cnt <= cnt + 1'b1;
            end else if (do_rd && !do_wr) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign bus.dout  = dout_q;
    assign bus.full  = full_w;
    assign bus.empty = empty_w;
    assign bus.count = cnt;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;
`ifdef REG_FIFO_NOUT_EN
    assign bus.dout_n = ~dout_q;
`endif
endmodule

// File: tb/tb_reg_fifo.sv
// tb/tb_reg_fifo.sv - scoreboard bench for reg_fifo (WIDTH=8, DEPTH=4)
module tb_reg_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [7:0] exp_q[$];
    logic       rd_seen = 1'b0;

    reg_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

    reg_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every read request outside reset is one dout observation.
    always @(posedge clk) rd_seen <= bus.rd_en && !reset;

    always @(negedge clk) begin
        if (rd_seen) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL dout_unexpected: got %0h want no read", bus.dout);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.dout !== e) begin
                    bad++;
                    $display("FAIL dout: got %0h want %0h", bus.dout, e);
                end
            end
        end
    end

    // One clock: drive at negedge, push expected dout when reading, return at next negedge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic [7:0] e);
        bus.wr_en = w;
        bus.din   = d;
        bus.rd_en = r;
        if (r) exp_q.push_back(e);
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.din   = 8'hAA;
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full",  32'(bus.full), 0);
        chk("rst_dout",  32'(bus.dout), 0);
        chk("rst_ovf",   32'(bus.ovf), 0);
        chk("rst_udf",   32'(bus.udf), 0);
`ifdef REG_FIFO_NOUT_EN
        chk("rst_dout_n", 32'(bus.dout_n), 32'hFF);
`endif
        reset = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(negedge clk);

        cyc(0, 8'h00, 1, 8'h00);
        chk("udf_pulse", 32'(bus.udf), 1);
        cyc(0, 8'h00, 0, 8'h00);
        chk("udf_clear", 32'(bus.udf), 0);

        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        cyc(1, 8'h44, 0, 0);
        chk("fill_full",  32'(bus.full), 1);
        chk("fill_count", 32'(bus.count), 4);
        chk("fill_empty", 32'(bus.empty), 0);

        cyc(1, 8'h55, 0, 0);
        chk("ovf_pulse", 32'(bus.ovf), 1);
        chk("ovf_count", 32'(bus.count), 4);
        cyc(0, 8'h00, 0, 0);
        chk("ovf_clear", 32'(bus.ovf), 0);

        cyc(0, 0, 1, 8'h11);
        cyc(0, 0, 1, 8'h22);
        cyc(0, 0, 1, 8'h33);
        cyc(0, 0, 1, 8'h44);
        chk("drain_empty", 32'(bus.empty), 1);
        chk("drain_count", 32'(bus.count), 0);

        cyc(1, 8'hA1, 0, 0);
        cyc(1, 8'hA2, 0, 0);
        cyc(1, 8'hA3, 0, 0);
        cyc(1, 8'hA4, 0, 0);
        cyc(1, 8'h77, 1, 8'hA1);
        chk("both_full_count", 32'(bus.count), 4);
        chk("both_full_ovf",   32'(bus.ovf), 0);
        cyc(0, 0, 1, 8'hA2);
        cyc(0, 0, 1, 8'hA3);
        cyc(0, 0, 1, 8'hA4);
        cyc(0, 0, 1, 8'h77);
        chk("drain2_empty", 32'(bus.empty), 1);

        cyc(1, 8'h66, 1, 8'h77);
        chk("both_empty_count", 32'(bus.count), 1);
        chk("both_empty_udf",   32'(bus.udf), 1);
        cyc(0, 0, 1, 8'h66);
        chk("both_empty_drain", 32'(bus.empty), 1);

        for (int i = 1; i <= 10; i++) begin
            cyc(1, 8'(i), 0, 0);
            chk("wrap_ovf_w", 32'(bus.ovf | bus.udf), 0);
            cyc(0, 0, 1, 8'(i));
            chk("wrap_ovf_r", 32'(bus.ovf | bus.udf), 0);
        end
        chk("wrap_empty", 32'(bus.empty), 1);

        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h02, 0, 0);
        cyc(1, 8'h03, 0, 0);
        chk("mid_count", 32'(bus.count), 3);
        reset = 1'b1;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.din   = 8'hEE;
        @(negedge clk);
        reset = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        chk("mid_rst_empty", 32'(bus.empty), 1);
        chk("mid_rst_count", 32'(bus.count), 0);
        chk("mid_rst_dout",  32'(bus.dout), 0);
        cyc(1, 8'h99, 0, 0);
        cyc(0, 0, 1, 8'h99);
        chk("mid_final_empty", 32'(bus.empty), 1);
`ifdef REG_FIFO_NOUT_EN
        chk("mid_dout_n", 32'(bus.dout_n), 32'h66);
`endif

        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
